// File: rtl/seq_det.sv
// -----------------------------------------------------------------------------
// seq_det
//   Serial pattern detector for the bit pattern "101". It samples one bit per
//   clock, and overlapping matches are counted. The detector is a Moore FSM, so
//   the match flag is decoded from the registered state only. The flag rises on
//   the edge that samples the final '1' of a match and stays high for one cycle.
//
// Ports
//   clock   in   1  system clock, rising-edge active
//   reset   in   1  synchronous active-low reset; forces the FSM to IDLE
//   seq_in  in   1  serial data bit, sampled on the rising edge
//   det_o   out  1  high while the FSM is in S101 (one cycle per match)
// -----------------------------------------------------------------------------
module seq_det (
   input  logic clock,
   input  logic reset,
   input  logic seq_in,
   output logic det_o
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      S1   = 2'b01,
      S10  = 2'b10,
      S101 = 2'b11
   } state_t;

   // The state register keeps the plain name 'state' so it can be probed
   // hierarchically.
   state_t state;
   state_t state_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    state_d = seq_in ? S1   : IDLE;
         S1:      state_d = seq_in ? S1   : S10;
         S10:     state_d = seq_in ? S101 : IDLE;
         // A '0' after a match reuses the trailing "10" of the match.
         S101:    state_d = seq_in ? S1   : S10;
         default: state_d = IDLE;
      endcase
   end

   // Decoding from the registered state keeps seq_in off the output path.
   assign det_o = (state == S101);

endmodule

// File: tb/tb_seq_det.sv
module tb_seq_det;

   logic clock  = 1'b0;
   logic reset  = 1'b0;
   logic seq_in = 1'b0;
   logic det_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] st;
      logic       det;
      string      tag;
   } exp_t;

   exp_t scb[$];

   seq_det dut (
      .clock  (clock),
      .reset  (reset),
      .seq_in (seq_in),
      .det_o  (det_o)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
      $fatal(1, "watchdog");
   end

   task automatic check_out();
      exp_t e;
      checks++;
      assert (scb.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard_empty observed=%0d expected>0", scb.size());
      end
      if (scb.size() != 0) begin
         e = scb.pop_front();
         checks++;
         assert (dut.state === e.st) else begin
            errors++;
            $error("FAIL %s state observed=%b expected=%b", e.tag, dut.state, e.st);
         end
         checks++;
         assert (det_o === e.det) else begin
            errors++;
            $error("FAIL %s det_o observed=%b expected=%b", e.tag, det_o, e.det);
         end
         checks++;
         assert (det_o === (dut.state == 2'b11)) else begin
            errors++;
            $error("FAIL %s moore_decode det_o=%b state=%b", e.tag, det_o, dut.state);
         end
      end
   endtask

   // Drive one bit (and reset level) away from the active edge, record the
   // expected registered result, then compare just after the rising edge.
   task automatic step(input logic rst_n, input logic b,
                       input logic [1:0] st, input logic det, input string tag);
      exp_t e;
      @(negedge clock);
      reset  = rst_n;
      seq_in = b;
      e.st  = st;
      e.det = det;
      e.tag = tag;
      scb.push_back(e);
      @(posedge clock);
      #1;
      check_out();
   endtask

   initial begin
      // Test 1: reset from power-up, with either input value.
      step(1'b0, 1'b0, 2'b00, 1'b0, "t1_rst_a");
      step(1'b0, 1'b1, 2'b00, 1'b0, "t1_rst_b");

      // Test 2: 0,1,0,1,0,1,1.
      step(1'b1, 1'b0, 2'b00, 1'b0, "t2_b1");
      step(1'b1, 1'b1, 2'b01, 1'b0, "t2_b2");
      step(1'b1, 1'b0, 2'b10, 1'b0, "t2_b3");
      step(1'b1, 1'b1, 2'b11, 1'b1, "t2_b4");
      step(1'b1, 1'b0, 2'b10, 1'b0, "t2_b5");
      step(1'b1, 1'b1, 2'b11, 1'b1, "t2_b6");
      step(1'b1, 1'b1, 2'b01, 1'b0, "t2_b7");

      // Reset while in S101 with seq_in=1.
      step(1'b1, 1'b0, 2'b10, 1'b0, "t1b_pre1");
      step(1'b1, 1'b1, 2'b11, 1'b1, "t1b_pre2");
      step(1'b0, 1'b1, 2'b00, 1'b0, "t1b_rst_s101");

      // Test 3: 1,0, then a mid-stream reset, then 1,0,1,1.
      step(1'b1, 1'b1, 2'b01, 1'b0, "t3_b1");
      step(1'b1, 1'b0, 2'b10, 1'b0, "t3_b2");
      step(1'b0, 1'b1, 2'b00, 1'b0, "t3_rst");
      step(1'b1, 1'b1, 2'b01, 1'b0, "t3_p1");
      step(1'b1, 1'b0, 2'b10, 1'b0, "t3_p2");
      step(1'b1, 1'b1, 2'b11, 1'b1, "t3_p3");
      step(1'b1, 1'b1, 2'b01, 1'b0, "t3_p4");

      // Test 4: non-matching 1,1,0,0,1,1.
      step(1'b0, 1'b0, 2'b00, 1'b0, "t4_rst");
      step(1'b1, 1'b1, 2'b01, 1'b0, "t4_b1");
      step(1'b1, 1'b1, 2'b01, 1'b0, "t4_b2");
      step(1'b1, 1'b0, 2'b10, 1'b0, "t4_b3");
      step(1'b1, 1'b0, 2'b00, 1'b0, "t4_b4");
      step(1'b1, 1'b1, 2'b01, 1'b0, "t4_b5");
      step(1'b1, 1'b1, 2'b01, 1'b0, "t4_b6");

      // Test 5: overlap chain 1,0,1,0,1,0,1.
      step(1'b0, 1'b0, 2'b00, 1'b0, "t5_rst");
      step(1'b1, 1'b1, 2'b01, 1'b0, "t5_b1");
      step(1'b1, 1'b0, 2'b10, 1'b0, "t5_b2");
      step(1'b1, 1'b1, 2'b11, 1'b1, "t5_b3");
      step(1'b1, 1'b0, 2'b10, 1'b0, "t5_b4");
      step(1'b1, 1'b1, 2'b11, 1'b1, "t5_b5");
      step(1'b1, 1'b0, 2'b10, 1'b0, "t5_b6");
      step(1'b1, 1'b1, 2'b11, 1'b1, "t5_b7");

      // Idle path: S10 followed by '0' returns to IDLE, which then holds on '0'.
      step(1'b1, 1'b0, 2'b10, 1'b0, "t6_b1");
      step(1'b1, 1'b0, 2'b00, 1'b0, "t6_b2");
      step(1'b1, 1'b0, 2'b00, 1'b0, "t6_b3");

      checks++;
      assert (scb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", scb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
